// File: rtl/pe_result_accum_if.sv
// Handshake, configuration and status bundle between the PE result stream,
// the group accumulator and the write-back consumer.
interface pe_result_accum_if #(
  parameter int RESULT_WIDTH = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int OUT_WIDTH    = 16
);
  logic        [LEN_WIDTH-1:0]    cfg_len;
  logic        [3:0]              cfg_shift;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [RESULT_WIDTH-1:0] in_result;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUT_WIDTH-1:0]    out_data;
  logic                           out_sat;
  logic                           busy;

  // Driver side: the PE plus the consumer of completed groups.
  modport master (
    output cfg_len, cfg_shift, in_valid, in_result, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  // Accumulator side.
  modport slave (
    input  cfg_len, cfg_shift, in_valid, in_result, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/pe_result_accum.sv
// Sums groups of consecutive signed PE results, rescales each group sum by an
// arithmetic right shift and saturates it into a one-deep valid/ready output.
module pe_result_accum #(
  parameter int RESULT_WIDTH = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int OUT_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  pe_result_accum_if.slave bus
);

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH:0] LEN_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  // A programmed length of zero stands for the full 2^LEN_WIDTH group.
  function automatic logic [LEN_WIDTH:0] decode_len(input logic [LEN_WIDTH-1:0] l);
    return (l == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, l};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] shift_floor(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic        [3:0]           s
  );
    return v >>> s;
  endfunction

  // Returns {clamped, value}; value is the low OUT_WIDTH bits after clamping.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] c;
    logic                        clamped;
    c       = v;
    clamped = 1'b0;
    if (v > OUT_MAX) begin
      c       = OUT_MAX;
      clamped = 1'b1;
    end else if (v < OUT_MIN) begin
      c       = OUT_MIN;
      clamped = 1'b1;
    end
    return {clamped, c[OUT_WIDTH-1:0]};
  endfunction

  logic signed [ACC_WIDTH-1:0] acc;
  logic        [LEN_WIDTH-1:0] cnt;
  logic        [LEN_WIDTH-1:0] len_q;
  logic        [3:0]           shift_q;

  logic signed [OUT_WIDTH-1:0] out_data_p1;
  logic                        out_sat_p1;
  logic                        vld_p1;

  logic                        first_p0;
  logic        [LEN_WIDTH:0]   eff_len_p0;
  logic        [3:0]           eff_shift_p0;
  logic                        last_p0;
  logic                        in_ready_p0;
  logic                        in_beat_p0;
  logic                        out_beat_p0;
  logic signed [ACC_WIDTH-1:0] sum_p0;
  logic signed [ACC_WIDTH-1:0] shifted_p0;
  logic        [OUT_WIDTH:0]   sat_res_p0;

  // Stage p0: beat decode, running sum and the rescaled/saturated candidate.
  always_comb begin
    first_p0     = (cnt == '0);
    eff_len_p0   = first_p0 ? decode_len(bus.cfg_len) : decode_len(len_q);
    eff_shift_p0 = first_p0 ? bus.cfg_shift : shift_q;
    last_p0      = ({1'b0, cnt} == (eff_len_p0 - LEN_ONE));
    // Only a completing beat needs the output slot, so only it can stall.
    in_ready_p0  = !(last_p0 && vld_p1 && !bus.out_ready);
    in_beat_p0   = bus.in_valid && in_ready_p0;
    out_beat_p0  = vld_p1 && bus.out_ready;
    sum_p0       = acc + {{(ACC_WIDTH-RESULT_WIDTH){bus.in_result[RESULT_WIDTH-1]}},
                          bus.in_result};
    shifted_p0   = shift_floor(sum_p0, eff_shift_p0);
    sat_res_p0   = saturate(shifted_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      shift_q <= '0;
    end else if (in_beat_p0) begin
      if (first_p0) begin
        len_q   <= bus.cfg_len;
        shift_q <= bus.cfg_shift;
      end
      if (last_p0) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_p0;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Stage p1: one-deep output register; a completion while draining refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_sat_p1  <= 1'b0;
    end else begin
      if (in_beat_p0 && last_p0) begin
        vld_p1      <= 1'b1;
        out_data_p1 <= sat_res_p0[OUT_WIDTH-1:0];
        out_sat_p1  <= sat_res_p0[OUT_WIDTH];
      end else if (out_beat_p0) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_sat   = out_sat_p1;
  assign bus.busy      = (cnt != '0);

endmodule

// File: tb/tb_pe_result_accum.sv
// Bench for pe_result_accum: directed scenarios with literal expectations plus
// randomized traffic, all checked against a group-level model every cycle.
module tb_pe_result_accum;
  localparam int RW = 16;
  localparam int LW = 8;
  localparam int AW = 24;
  localparam int OW = 16;
  localparam longint OMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_result_accum_if #(.RESULT_WIDTH(RW), .LEN_WIDTH(LW), .OUT_WIDTH(OW)) bus_if ();

  pe_result_accum #(.RESULT_WIDTH(RW), .LEN_WIDTH(LW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: the group in progress (beats taken, running sum, latched length
  // and shift) and the single output slot.
  int     m_cnt   = 0;
  int     m_len   = 0;
  int     m_shift = 0;
  longint m_sum   = 0;
  bit     m_ov    = 0;
  longint m_data  = 0;
  bit     m_sat   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int group_len(input int l);
    return (l == 0) ? (1 << LW) : l;
  endfunction

  function automatic bit model_last();
    int el;
    el = (m_cnt == 0) ? group_len(int'(bus_if.cfg_len)) : m_len;
    return m_cnt == el - 1;
  endfunction

  function automatic bit model_ready();
    return !(model_last() && m_ov && !bus_if.out_ready);
  endfunction

  function automatic longint floor_div_pow2(input longint v, input int s);
    longint d;
    d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  initial begin
    bit     take, lst, drained;
    int     sh;
    longint v;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_len = 0; m_shift = 0; m_sum = 0;
        m_ov = 0; m_data = 0; m_sat = 0;
      end else begin
        take    = bus_if.in_valid && model_ready();
        lst     = model_last();
        sh      = (m_cnt == 0) ? int'(bus_if.cfg_shift) : m_shift;
        drained = m_ov && bus_if.out_ready;
        if (take) begin
          if (m_cnt == 0) begin
            m_len   = group_len(int'(bus_if.cfg_len));
            m_shift = int'(bus_if.cfg_shift);
          end
          m_sum = m_sum + longint'(bus_if.in_result);
          if (lst) begin
            v = floor_div_pow2(m_sum, sh);
            if (v > OMAX)      begin m_data = OMAX; m_sat = 1; end
            else if (v < OMIN) begin m_data = OMIN; m_sat = 1; end
            else               begin m_data = v;    m_sat = 0; end
            m_ov  = 1;
            m_sum = 0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        if (!(take && lst) && drained) m_ov = 0;
      end
    end
  end

  // Every-cycle comparison on the falling edge, away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", bus_if.out_valid, m_ov);
      chk("busy", bus_if.busy, m_cnt != 0);
      chk("in_ready", bus_if.in_ready, model_ready());
      if (m_ov) begin
        chk("out_data", bus_if.out_data, m_data);
        chk("out_sat", bus_if.out_sat, m_sat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val);
    bit ok;
    ok = 0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_result = RW'(val);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = bus_if.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus_if.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input string name, input longint data, input bit sat);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus_if.out_valid) begin seen = 1; break; end
      step();
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_data"}, bus_if.out_data, data);
      chk({name, "_sat"}, bus_if.out_sat, sat);
    end
  endtask

  initial begin
    int r;
    bus_if.cfg_len   = 8'd4;
    bus_if.cfg_shift = 4'd0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_result = '0;
    bus_if.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", bus_if.out_valid, 0);
    chk("reset_out_data", bus_if.out_data, 0);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_in_ready", bus_if.in_ready, 1);

    // Basic four-beat group.
    send(10); send(-3); send(7); send(1);
    expect_out("basic", 15, 0);
    chk("model_pin_basic", m_data, 15);
    step();
    chk("basic_busy_after", bus_if.busy, 0);
    chk("basic_pulse_end", bus_if.out_valid, 0);

    // Saturation and floor shift.
    bus_if.cfg_len = 8'd2;
    send(32767); send(32767);
    expect_out("sat_shift0", 32767, 1);
    step();
    bus_if.cfg_shift = 4'd1;
    send(32767); send(32767);
    expect_out("sat_shift1", 32767, 0);
    step();
    send(-5); send(0);
    expect_out("floor_neg", -3, 0);
    chk("model_pin_floor", m_data, -3);
    step();

    // Backpressure with single-beat groups.
    bus_if.cfg_len   = 8'd1;
    bus_if.cfg_shift = 4'd0;
    bus_if.out_ready = 1'b0;
    send(100);
    expect_out("bp_first", 100, 0);
    bus_if.in_valid  = 1'b1;
    bus_if.in_result = RW'(200);
    @(negedge clk);
    chk("bp_stall_ready", bus_if.in_ready, 0);
    step(); step();
    @(negedge clk);
    chk("bp_hold_data", bus_if.out_data, 100);
    chk("bp_hold_ready", bus_if.in_ready, 0);
    step();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", bus_if.in_ready, 1);
    step();
    bus_if.in_valid = 1'b0;
    chk("bp_valid_kept", bus_if.out_valid, 1);
    chk("bp_new_data", bus_if.out_data, 200);
    step();

    // Maximum-length groups.
    bus_if.cfg_len   = 8'd0;
    bus_if.cfg_shift = 4'd8;
    for (int i = 0; i < 256; i++) send(-32768);
    expect_out("maxlen_shift8", -32768, 0);
    step();
    bus_if.cfg_shift = 4'd0;
    for (int i = 0; i < 256; i++) send(-32768);
    expect_out("maxlen_shift0", -32768, 1);
    chk("model_pin_maxlen", m_sat, 1);
    step();

    // Configuration change inside a group.
    bus_if.cfg_len = 8'd3;
    send(1);
    bus_if.cfg_len = 8'd1;
    send(2);
    chk("cfg_busy_mid", bus_if.busy, 1);
    chk("cfg_no_early_out", bus_if.out_valid, 0);
    send(3);
    expect_out("cfg_group3", 6, 0);
    step();
    send(9);
    expect_out("cfg_next_len1", 9, 0);
    step();

    // Reset in the middle of a group with a stalled output.
    bus_if.out_ready = 1'b0;
    send(5);
    bus_if.cfg_len = 8'd4;
    send(1); send(1);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_data", bus_if.out_data, 0);
    chk("rst_out_sat", bus_if.out_sat, 0);
    chk("rst_busy", bus_if.busy, 0);
    step(); step();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(1);
    expect_out("rst_new_group", 4, 0);
    step();

    // Randomized traffic, gaps, stalls and mid-group configuration changes.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 39);
        bus_if.cfg_len   = (r == 0) ? 8'd0 : LW'($urandom_range(1, 7));
        bus_if.cfg_shift = 4'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 9);
      bus_if.in_result = (r == 0) ? RW'(32767) : (r == 1) ? RW'(-32768) : RW'($urandom);
      bus_if.in_valid  = ($urandom_range(0, 9) < 7);
      bus_if.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_result_accum.md
Name: pe_result_accum

Overview:
- Downstream stage of the processing element (PE). Consumes the 16-bit signed result stream the PE produces.
- Sums a configurable number of consecutive results into one signed value.
- Rescales the sum by an arithmetic right shift, saturates it to the output width and presents it on a valid/ready output port.
- Sits between the PE array and the result write-back buffer. Frees the PE from carrying partial sums across weight passes.

Parameters:
- RESULT_WIDTH, 16, width of the PE result (signed two's complement).
- LEN_WIDTH, 8, width of cfg_len; a group holds up to 2^LEN_WIDTH results.
- ACC_WIDTH, 24, accumulator width; must be >= RESULT_WIDTH+LEN_WIDTH, so the accumulator cannot overflow.
- OUT_WIDTH, 16, width of the saturated output (signed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  LEN_WIDTH  results per group; 0 means 2^LEN_WIDTH.
- cfg_shift  in  4  arithmetic right-shift amount applied to the final sum.
- in_valid  in  1  PE result valid.
- in_ready  out  1  block accepts the PE result this cycle.
- in_result  in  RESULT_WIDTH  signed PE result.
- out_valid  out  1  out_data holds a completed group.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  OUT_WIDTH  signed, shifted, saturated group sum.
- out_sat  out  1  saturation occurred on this out_data.
- busy  out  1  a group is partially accumulated (cnt != 0).

Behaviour:
- Reset, asynchronous, active-high. Immediately clears: acc=0, cnt=0, len_q=0, shift_q=0, out_valid=0, out_data=0, out_sat=0, busy=0. An in-flight group is discarded.
- Transfers: an input beat occurs when in_valid && in_ready. An output beat occurs when out_valid && out_ready.
- Config latching: cfg_len and cfg_shift are latched into len_q/shift_q on the first beat of a group (cnt==0). Changes mid-group are ignored until the next group.
  - The first beat uses cfg_len/cfg_shift directly. A group of length 1 therefore completes on that same beat.
- Last-beat decode: last = (cnt == eff_len-1).
  - eff_len = cfg_len on the first beat, len_q otherwise.
  - A value of 0 decodes to 2^LEN_WIDTH.
- Non-last beat: acc <= acc + sext(in_result); cnt <= cnt+1.
- Last beat:
  - sum = acc + sext(in_result), all in ACC_WIDTH.
  - shifted = sum >>> shift (arithmetic, floor).
  - Saturate shifted to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. out_sat=1 iff clamped.
  - Register the result into out_data/out_sat; set out_valid=1.
  - acc <= 0; cnt <= 0.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. one cycle after that beat is presented.
- Backpressure (output register is one deep):
  - in_ready = !(last_pending && out_valid && !out_ready), where last_pending means the next beat would be the last.
  - Non-last beats are always accepted, even while the output is stalled.
  - A last beat is accepted in the same cycle the old output drains; out_valid stays 1 and carries the new data.
- out_valid clears only on an output beat with no simultaneous completion.
- out_data/out_sat remain stable while out_valid && !out_ready.
- busy = (cnt != 0).
- No internal state machine beyond the cnt counter and the output-register valid. Effective states: ACCUM (cnt counting) and OUTPUT_FULL (out_valid). These states are orthogonal.
- Wrap-around: cnt wraps to 0 only via the last-beat path. With cfg_len=0, cnt runs 0..2^LEN_WIDTH-1.
- in_valid=0 cycles freeze acc/cnt; gaps between beats are permitted.

Test Plan:
- Basic group: cfg_len=4, cfg_shift=0; results 10, -3, 7, 1 on back-to-back cycles with out_ready=1.
  - Expect out_valid pulse one cycle after the 4th beat, out_data=15, out_sat=0, busy=0 afterward.
- Shift and saturation: cfg_len=2, shift=0; inputs 32767, 32767.
  - Expect out_data=32767, out_sat=1.
  - Repeat with shift=1: expect out_data=32767, out_sat=0.
  - Inputs -5, 0 with shift=1: expect out_data=-3 (floor).
- Backpressure: cfg_len=1, out_ready=0; send 100 then 200.
  - First beat is accepted; out_data=100 holds.
  - in_ready=0 for the second beat until out_ready=1.
  - In that same cycle 200 is accepted; out_valid stays 1; next out_data=200.
- Max length: cfg_len=0; 256 beats of -32768.
  - Expect sum -8388608 with no internal overflow.
  - shift=8 gives -32768, out_sat=0.
  - shift=0 gives -32768, out_sat=1.
- Config change mid-group: cfg_len=3 at the first beat, changed to 1 after the first beat.
  - Group still completes after exactly 3 beats.
  - The next group uses length 1.
- Reset mid-operation: assert rst after 2 of 4 beats with out_valid=1 pending.
  - All outputs clear immediately.
  - A new 4-beat group of 1s afterward yields out_data=4.
